// File: rtl/fc_mapper_pkg.sv
// Shared types and defaults for the FC discrete-logic mapper family.
// The bus payload gains a PRG data field when FC_MAPPER_BUS_CONFLICT_EN is defined.
package fc_mapper_pkg;

    typedef enum logic [1:0] {
        UXROM = 2'd0,
        M94   = 2'd1,
        M180  = 2'd2,
        CNROM = 2'd3
    } mapper_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIGH   = 2'd1,
        COMMIT = 2'd2
    } fsm_state_t;

    localparam int unsigned M2_FILTER_DEF    = 3;
    localparam int unsigned IDLE_TIMEOUT_DEF = 2500000;

    // CPU bus sample carried through the pipe alongside the synchronised M2
    typedef struct packed {
        logic       romsel;
        logic       rw;
        logic [7:0] data;
`ifdef FC_MAPPER_BUS_CONFLICT_EN
        logic [7:0] prg_data;
`endif
    } cpu_bus_t;

endpackage

// File: rtl/fc_m2_sync.sv
// Two-flop synchroniser for CPU M2 with single-cycle rise/fall indications.
module fc_m2_sync (
    input  logic osc50,
    input  logic m2_rst,
    input  logic m2,
    output logic m2_s,
    output logic m2_rise_c,
    output logic m2_fall_c
);

    logic m2_meta;
    logic m2_d;

    always_ff @(posedge osc50) begin
        if (m2_rst) begin
            m2_meta <= 1'b0;
            m2_s    <= 1'b0;
            m2_d    <= 1'b0;
        end else begin
            m2_meta <= m2;
            m2_s    <= m2_meta;
            m2_d    <= m2_s;
        end
    end

    assign m2_rise_c = m2_s & ~m2_d;
    assign m2_fall_c = ~m2_s & m2_d;

endmodule

// File: rtl/fc_discrete_mapper.sv
// UxROM / mapper 94 / mapper 180 / CNROM bank latch with M2 pulse filter and idle watchdog.
// Optional FC_MAPPER_BUS_CONFLICT_EN ANDs the written value with PRG ROM output data.
module fc_discrete_mapper
    import fc_mapper_pkg::*;
#(
    parameter int unsigned MODE         = 1,
    parameter int unsigned PRG_BANK_W   = 3,
    parameter int unsigned CHR_BANK_W   = 2,
    parameter int unsigned MIRROR_V     = 1,
    parameter int unsigned M2_FILTER    = M2_FILTER_DEF,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic                  osc50,
    input  logic                  m2_rst,
    input  logic                  m2,
    input  logic                  romsel,
    input  logic                  cpu_rw_in,
    input  logic [7:0]            cpu_data,
    input  logic [14:0]           cpu_addr_in,
`ifdef FC_MAPPER_BUS_CONFLICT_EN
    input  logic [7:0]            prg_data_in,
`endif
    input  logic [2:0]            ppu_addr_in,
    output logic [PRG_BANK_W:0]   prg_addr_out,
    output logic [CHR_BANK_W+2:0] chr_addr_out,
    output logic                  ppu_ciram_a10,
    output logic                  bank_wr
);

    localparam mapper_mode_t MODE_E = mapper_mode_t'(2'(MODE));
    localparam int unsigned HI_W = $clog2(M2_FILTER + 2);
    localparam int unsigned WD_W = $clog2(IDLE_TIMEOUT + 2);
    localparam logic [HI_W-1:0] HI_MAX    = HI_W'(M2_FILTER);
    localparam logic [HI_W-1:0] HI_ACCEPT = HI_W'((M2_FILTER > 0) ? (M2_FILTER - 1) : 0);
    localparam logic [WD_W-1:0] WD_MAX    = WD_W'(IDLE_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'((IDLE_TIMEOUT > 0) ? (IDLE_TIMEOUT - 1) : 0);

    logic                  m2_s;
    logic                  m2_rise_c;
    logic                  m2_fall_c;
    logic                  m2_edge_c;
    logic                  wd_expire_c;
    logic                  accept_c;
    logic [7:0]            wr_data_c;
    logic [PRG_BANK_W-1:0] prg_load_c;
    logic [CHR_BANK_W-1:0] chr_load_c;
    logic [PRG_BANK_W-1:0] prg_sel_c;
    logic                  unused_addr;

    cpu_bus_t              bus_in;
    cpu_bus_t              bus_p1;
    cpu_bus_t              bus_p2;
    cpu_bus_t              shadow;
    fsm_state_t            state;
    logic [HI_W-1:0]       hi_cnt;
    logic [WD_W-1:0]       wd_cnt;
    logic [PRG_BANK_W-1:0] prg_bank;
    logic [CHR_BANK_W-1:0] chr_bank;

    fc_m2_sync u_m2_sync (
        .osc50     (osc50),
        .m2_rst    (m2_rst),
        .m2        (m2),
        .m2_s      (m2_s),
        .m2_rise_c (m2_rise_c),
        .m2_fall_c (m2_fall_c)
    );

    always_comb begin
        bus_in        = '0;
        bus_in.romsel = romsel;
        bus_in.rw     = cpu_rw_in;
        bus_in.data   = cpu_data;
`ifdef FC_MAPPER_BUS_CONFLICT_EN
        bus_in.prg_data = prg_data_in;
`endif
    end

    // Bus pipe matches the synchroniser depth so samples line up with m2_s
    always_ff @(posedge osc50) begin
        if (m2_rst) begin
            bus_p1 <= '0;
            bus_p2 <= '0;
        end else begin
            bus_p1 <= bus_in;
            bus_p2 <= bus_p1;
        end
    end

`ifdef FC_MAPPER_BUS_CONFLICT_EN
    assign wr_data_c = shadow.data & shadow.prg_data;
`else
    assign wr_data_c = shadow.data;
`endif

    assign m2_edge_c   = m2_rise_c | m2_fall_c;
    assign wd_expire_c = (wd_cnt == WD_LAST) && !m2_edge_c;
    // The rise-detect cycle is itself the first counted high cycle
    assign accept_c    = (hi_cnt >= HI_ACCEPT) && !shadow.romsel && !shadow.rw;

    always_comb begin
        prg_load_c = prg_bank;
        chr_load_c = chr_bank;
        case (MODE_E)
            UXROM, M180: prg_load_c = wr_data_c[PRG_BANK_W-1:0];
            M94:         prg_load_c = PRG_BANK_W'(wr_data_c >> 2);
            CNROM:       chr_load_c = wr_data_c[CHR_BANK_W-1:0];
            default:     ;
        endcase
    end

    // Write-qualification FSM, bank registers and idle watchdog
    always_ff @(posedge osc50) begin
        if (m2_rst) begin
            state    <= IDLE;
            hi_cnt   <= '0;
            wd_cnt   <= '0;
            shadow   <= '0;
            prg_bank <= '0;
            chr_bank <= '0;
            bank_wr  <= 1'b0;
        end else begin
            bank_wr <= 1'b0;

            if (m2_edge_c) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end

            if (wd_expire_c) begin
                prg_bank <= '0;
                chr_bank <= '0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (m2_rise_c) begin
                            hi_cnt <= '0;
                            shadow <= bus_p2;
                            state  <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (m2_fall_c) begin
                            state <= accept_c ? COMMIT : IDLE;
                        end else begin
                            if (hi_cnt != HI_MAX) begin
                                hi_cnt <= hi_cnt + HI_W'(1);
                            end
                            shadow <= bus_p2;
                        end
                    end
                    COMMIT: begin
                        prg_bank <= prg_load_c;
                        chr_bank <= chr_load_c;
                        bank_wr  <= 1'b1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        prg_sel_c = '0;
        case (MODE_E)
            UXROM, M94: prg_sel_c = cpu_addr_in[14] ? '1 : prg_bank;
            M180:       prg_sel_c = cpu_addr_in[14] ? prg_bank : '0;
            CNROM:      prg_sel_c = PRG_BANK_W'(cpu_addr_in[14]);
            default:    prg_sel_c = '0;
        endcase
    end

    assign prg_addr_out  = {prg_sel_c, cpu_addr_in[13]};
    assign chr_addr_out  = {chr_bank, ppu_addr_in};
    assign ppu_ciram_a10 = (MIRROR_V != 0) ? ppu_addr_in[0] : ppu_addr_in[1];
    assign unused_addr   = ^cpu_addr_in[12:0];

endmodule

// File: tb/tb_fc_discrete_mapper.sv
// Self-checking bench: one instance per MODE, table vectors, random writes, watchdog and reset corners.
module tb_fc_discrete_mapper;

    localparam int TO     = 300;
    localparam int FILTER = 3;
`ifdef FC_MAPPER_BUS_CONFLICT_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        osc50;
    logic        m2_rst;
    logic        m2;
    logic        romsel;
    logic        cpu_rw_in;
    logic [7:0]  cpu_data;
    logic [14:0] cpu_addr_in;
    logic [2:0]  ppu_addr_in;
`ifdef FC_MAPPER_BUS_CONFLICT_EN
    logic [7:0]  prg_data;
`endif

    logic [3:0]  prg_o [4];
    logic [4:0]  chr_o [4];
    logic        cir_o [4];
    logic        bw_o  [4];

    int n_tot;
    int n_bad;
    int m_prg [4];
    int m_chr [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fc_discrete_mapper #(
            .MODE         (g),
            .PRG_BANK_W   (3),
            .CHR_BANK_W   (2),
            .MIRROR_V     ((g < 2) ? 1 : 0),
            .M2_FILTER    (FILTER),
            .IDLE_TIMEOUT (TO)
        ) u_dut (
            .osc50         (osc50),
            .m2_rst        (m2_rst),
            .m2            (m2),
            .romsel        (romsel),
            .cpu_rw_in     (cpu_rw_in),
            .cpu_data      (cpu_data),
            .cpu_addr_in   (cpu_addr_in),
`ifdef FC_MAPPER_BUS_CONFLICT_EN
            .prg_data_in   (prg_data),
`endif
            .ppu_addr_in   (ppu_addr_in),
            .prg_addr_out  (prg_o[g]),
            .chr_addr_out  (chr_o[g]),
            .ppu_ciram_a10 (cir_o[g]),
            .bank_wr       (bw_o[g])
        );
    end

    initial osc50 = 1'b0;
    always #10 osc50 = ~osc50;

    task automatic chk(input string name, input int dut, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d got=%0d exp=%0d t=%0t", name, dut, act, exp, $time);
        end
    endtask

    // Reference: 8 KB PRG page number seen at CPU offset a (0..$7FFF above $8000)
    function automatic int exp_prg(input int mode, input int a);
        int b16;
        case (mode)
            0, 1:    b16 = (a >= 16384) ? 7 : m_prg[mode];
            2:       b16 = (a >= 16384) ? m_prg[2] : 0;
            default: b16 = a / 16384;
        endcase
        return b16 * 2 + (a / 8192) % 2;
    endfunction

    task automatic model_write(input int d, input int pd);
        int eff;
        eff      = BC ? (d & pd) : d;
        m_prg[0] = eff % 8;
        m_prg[1] = (eff / 4) % 8;
        m_prg[2] = eff % 8;
        m_chr[3] = eff % 4;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_prg[i] = 0;
            m_chr[i] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        int a;
        int p;
        for (int k = 0; k < 4; k++) begin
            a = k * 8192 + int'($urandom_range(0, 8191));
            p = int'($urandom_range(0, 7));
            cpu_addr_in = 15'(a);
            ppu_addr_in = 3'(p);
            #1;
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_prg"}, i, int'(prg_o[i]), exp_prg(i, a));
                chk({tag, "_chr"}, i, int'(chr_o[i]), m_chr[i] * 8 + p);
                chk({tag, "_ciram"}, i, int'(cir_o[i]), (i < 2) ? (p % 2) : ((p / 2) % 2));
            end
        end
    endtask

    task automatic check_bw(input string tag, input logic exp);
        for (int i = 0; i < 4; i++) chk(tag, i, int'(bw_o[i]), int'(exp));
    endtask

    // One CPU cycle: M2 high for hl osc50 periods, then latency and commit checks
    task automatic xfer(input logic [14:0] a, input logic [7:0] d, input logic [7:0] pd,
                        input logic rw, input logic rs, input int hl, input logic exp_c);
        @(posedge osc50); #1;
        cpu_addr_in = a;
        cpu_data    = d;
        cpu_rw_in   = rw;
        romsel      = rs;
`ifdef FC_MAPPER_BUS_CONFLICT_EN
        prg_data    = pd;
`endif
        m2 = 1'b1;
        repeat (hl) @(posedge osc50);
        #1 m2 = 1'b0;
        repeat (3) @(posedge osc50);
        #1;
        check_bw("bank_wr_early", 1'b0);
        check_outputs("pre_commit");
        @(posedge osc50); #1;
        check_bw("bank_wr_commit", exp_c);
        if (exp_c) model_write(int'(d), int'(pd));
        check_outputs("post_commit");
        @(posedge osc50); #1;
        check_bw("bank_wr_single", 1'b0);
        romsel    = 1'b1;
        cpu_rw_in = 1'b1;
    endtask

    typedef struct {
        logic [14:0] addr;
        logic [7:0]  data;
        logic [7:0]  pdata;
        logic        rw;
        logic        rs;
        int          hl;
        logic        exp_commit;
    } vec_t;

    vec_t tbl [8];

    initial begin
        n_tot = 0;
        n_bad = 0;
        model_clear();
        m2_rst      = 1'b1;
        m2          = 1'b0;
        romsel      = 1'b1;
        cpu_rw_in   = 1'b1;
        cpu_data    = 8'h00;
        cpu_addr_in = 15'h0000;
        ppu_addr_in = 3'd0;
`ifdef FC_MAPPER_BUS_CONFLICT_EN
        prg_data    = 8'hFF;
`endif

        tbl[0] = '{15'h0000, 8'h14, 8'hFF, 1'b0, 1'b0, 12, 1'b1};
        tbl[1] = '{15'h0000, 8'h03, 8'hFF, 1'b0, 1'b0, 5,  1'b1};
        tbl[2] = '{15'h4000, 8'h02, 8'hFF, 1'b0, 1'b0, 3,  1'b1};
        tbl[3] = '{15'h0000, 8'h07, 8'hFF, 1'b0, 1'b0, 2,  1'b0};
        tbl[4] = '{15'h0000, 8'h05, 8'hFF, 1'b1, 1'b0, 6,  1'b0};
        tbl[5] = '{15'h6000, 8'h06, 8'hFF, 1'b0, 1'b1, 6,  1'b0};
        tbl[6] = '{15'h7FFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 4,  1'b1};
        tbl[7] = '{15'h0000, 8'h0F, 8'h06, 1'b0, 1'b0, 4,  1'b1};

        repeat (3) @(posedge osc50);
        #1;
        check_bw("reset_bank_wr", 1'b0);
        check_outputs("reset");
        m2_rst = 1'b0;
        repeat (2) @(posedge osc50);

        // Test-plan anchors with fixed expectations
        xfer(tbl[0].addr, tbl[0].data, tbl[0].pdata, tbl[0].rw, tbl[0].rs, tbl[0].hl, tbl[0].exp_commit);
        cpu_addr_in = 15'h0000; #1;
        chk("m94_8000_bank5", 1, int'(prg_o[1]), 10);
        cpu_addr_in = 15'h4000; #1;
        chk("m94_c000_last", 1, int'(prg_o[1]), 14);
        xfer(tbl[1].addr, tbl[1].data, tbl[1].pdata, tbl[1].rw, tbl[1].rs, tbl[1].hl, tbl[1].exp_commit);
        cpu_addr_in = 15'h0000; #1;
        chk("m180_8000_bank0", 2, int'(prg_o[2]), 0);
        cpu_addr_in = 15'h4000; #1;
        chk("m180_c000_bank3", 2, int'(prg_o[2]), 6);
        xfer(tbl[2].addr, tbl[2].data, tbl[2].pdata, tbl[2].rw, tbl[2].rs, tbl[2].hl, tbl[2].exp_commit);
        ppu_addr_in = 3'b101;
        cpu_addr_in = 15'h4000; #1;
        chk("cnrom_chr_10101", 3, int'(chr_o[3]), 21);
        chk("cnrom_prg_linear", 3, int'(prg_o[3]), 2);

        for (int v = 3; v < 8; v++) begin
            xfer(tbl[v].addr, tbl[v].data, tbl[v].pdata, tbl[v].rw, tbl[v].rs, tbl[v].hl,
                 tbl[v].exp_commit);
        end

        for (int r = 0; r < 40; r++) begin
            logic        rw;
            logic        rs;
            int          hl;
            rw = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) == 0);
            hl = int'($urandom_range(1, 6));
            xfer(15'($urandom), 8'($urandom), 8'($urandom), rw, rs, hl,
                 (hl >= FILTER) && !rw && !rs);
        end

        // Watchdog: bank survives a long quiet stretch, then returns to 0
        xfer(15'h0000, 8'h05, 8'hFF, 1'b0, 1'b0, 4, 1'b1);
        repeat (TO - 20) @(posedge osc50);
        #1;
        check_outputs("wd_before");
        repeat (40) @(posedge osc50);
        #1;
        model_clear();
        check_outputs("wd_after");

        // Reset while in HIGH: no commit, registers cleared
        xfer(15'h0000, 8'h1B, 8'hFF, 1'b0, 1'b0, 4, 1'b1);
        @(posedge osc50); #1;
        cpu_data  = 8'h06;
        cpu_rw_in = 1'b0;
        romsel    = 1'b0;
        m2        = 1'b1;
        repeat (4) @(posedge osc50);
        #1;
        m2_rst = 1'b1;
        m2     = 1'b0;
        repeat (2) @(posedge osc50);
        #1 m2_rst = 1'b0;
        model_clear();
        for (int c = 0; c < 6; c++) begin
            @(posedge osc50); #1;
            check_bw("rst_high_bank_wr", 1'b0);
        end
        check_outputs("rst_high");

        // Reset while in COMMIT: reset wins
        xfer(15'h0000, 8'h0D, 8'hFF, 1'b0, 1'b0, 4, 1'b1);
        @(posedge osc50); #1;
        cpu_data  = 8'h12;
        cpu_rw_in = 1'b0;
        romsel    = 1'b0;
        m2        = 1'b1;
        repeat (4) @(posedge osc50);
        #1 m2 = 1'b0;
        repeat (3) @(posedge osc50);
        #1 m2_rst = 1'b1;
        @(posedge osc50);
        #1 m2_rst = 1'b0;
        model_clear();
        check_bw("rst_commit_bank_wr", 1'b0);
        check_outputs("rst_commit");
        for (int c = 0; c < 4; c++) begin
            @(posedge osc50); #1;
            check_bw("rst_commit_after", 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
